reg_dump_sequencer: RTL

// Hardware register-file dump engine sitting directly upstream of the pipeline's instruction port.

---
 rtl/dlx_pkg.sv | 25 ++
 rtl/dump_delay_line.sv | 39 +++
 rtl/reg_dump_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/dlx_pkg.sv
// Shared DLX definitions for the register-dump engine: opcodes, register-file
// geometry, dump FSM state encoding and the forced-instruction encoder.
package dlx_pkg;

    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam int         NUM_REGS  = 32;
    localparam int         REG_IDX_W = 5;
    localparam int         INST_W    = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRAIN = 3'd1,
        ISSUE = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } dump_state_t;

    // ADDI r0, rs1, 0 : puts register rs1 on busA in decode without side effects.
    function automatic logic [INST_W-1:0] read_inst(input logic [REG_IDX_W-1:0] r);
        return {OP_ADDI, r, 5'b00000, 16'h0000};
    endfunction

    localparam logic [INST_W-1:0] NOP_INST = {OP_ADDI, 5'd0, 5'd0, 16'h0000};

endpackage

// File: rtl/dump_delay_line.sv
// Fixed-length shift register that tracks {valid, idx} of each forced read
// until its busA value is due, plus an OR of all valid bits for flush detection.
module dump_delay_line #(
    parameter int LATENCY = 1,
    parameter int W       = 6
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         any_valid
);

    logic [LATENCY-1:0][W-1:0] stage_reg;
    logic [LATENCY-1:0]        stage_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_reg <= '0;
        end else begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                stage_reg[i] <= stage_reg[i-1];
            end
            stage_reg[0] <= din;
        end
    end

    // Valid flag lives in the MSB of every stage.
    genvar gi;
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : g_valid
            assign stage_valid[gi] = stage_reg[gi][W-1];
        end
    endgenerate

    assign dout      = stage_reg[LATENCY-1];
    assign any_valid = |stage_valid;

endmodule

// File: rtl/reg_dump_sequencer.sv
// Register-file dump engine in front of the pipeline instruction port: drains the
// pipeline, forces one ADDI read per register and streams (index, busA) records.
module reg_dump_sequencer
    import dlx_pkg::*;
#(
    parameter int LATENCY      = 1,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [INST_W-1:0]    fetch_inst,
    input  logic [INST_W-1:0]    busA_probe,
    output logic [INST_W-1:0]    inst_out,
    output logic                 override,
    output logic                 busy,
    output logic                 dump_valid,
    output logic [REG_IDX_W-1:0] dump_idx,
    output logic [INST_W-1:0]    dump_data,
    output logic                 done
);

    localparam int                  DCW        = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCW-1:0]      DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);
    localparam logic [REG_IDX_W-1:0] LAST_REG  = REG_IDX_W'(NUM_REGS - 1);
    localparam int                  LINE_W     = REG_IDX_W + 1;

    dump_state_t          state_reg, state_next;
    logic [DCW-1:0]       drain_cnt_reg, drain_cnt_next;
    logic [REG_IDX_W-1:0] iss_idx_reg, iss_idx_next;
    logic [INST_W-1:0]    forced_inst;
    logic                 push_valid;

    logic                 override_reg, busy_reg, done_reg;
    logic                 dump_valid_reg;
    logic [REG_IDX_W-1:0] dump_idx_reg;
    logic [INST_W-1:0]    dump_data_reg;

    logic [LINE_W-1:0]    line_in, line_out;
    logic                 line_any_valid;

    always_comb begin
        state_next     = state_reg;
        drain_cnt_next = drain_cnt_reg;
        iss_idx_next   = iss_idx_reg;
        forced_inst    = NOP_INST;
        push_valid     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next     = DRAIN;
                    drain_cnt_next = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                if (drain_cnt_reg == '0) begin
                    state_next   = ISSUE;
                    iss_idx_next = '0;
                end else begin
                    drain_cnt_next = drain_cnt_reg - 1'b1;
                end
            end
            ISSUE: begin
                forced_inst = read_inst(iss_idx_reg);
                push_valid  = 1'b1;
                // Terminal count is tested before incrementing so the index never wraps here.
                if (iss_idx_reg == LAST_REG) begin
                    state_next = FLUSH;
                end else begin
                    iss_idx_next = iss_idx_reg + 1'b1;
                end
            end
            FLUSH: begin
                if (!line_any_valid) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            drain_cnt_reg <= '0;
            iss_idx_reg   <= '0;
            override_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            drain_cnt_reg <= drain_cnt_next;
            iss_idx_reg   <= iss_idx_next;
            // Decoded from the next state so these flags line up with state_reg.
            override_reg  <= (state_next == DRAIN) || (state_next == ISSUE) || (state_next == FLUSH);
            busy_reg      <= (state_next != IDLE);
            done_reg      <= (state_next == DONE);
        end
    end

    assign line_in = {push_valid, iss_idx_reg};

    dump_delay_line #(
        .LATENCY (LATENCY),
        .W       (LINE_W)
    ) u_delay_line (
        .clk       (clk),
        .reset_n   (reset_n),
        .din       (line_in),
        .dout      (line_out),
        .any_valid (line_any_valid)
    );

    // When a tracked read reaches the output stage its register value is on busA now.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dump_valid_reg <= 1'b0;
            dump_idx_reg   <= '0;
            dump_data_reg  <= '0;
        end else if (line_out[LINE_W-1]) begin
            dump_valid_reg <= 1'b1;
            dump_idx_reg   <= line_out[REG_IDX_W-1:0];
            dump_data_reg  <= busA_probe;
        end else begin
            dump_valid_reg <= 1'b0;
        end
    end

    assign inst_out   = override_reg ? forced_inst : fetch_inst;
    assign override   = override_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign dump_valid = dump_valid_reg;
    assign dump_idx   = dump_idx_reg;
    assign dump_data  = dump_data_reg;

endmodule
